// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with busy-bit scoreboard, entry 0 hardwired zero
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   rs_addr/rs_data/rs_busy : NR combinational read ports (data and busy bit)
//   wr_en/wr_addr/wr_data : NW write ports; a write also releases the busy bit
//   alloc_en/alloc_addr   : marks one destination busy at issue
//   busy_vec, err_waw     : registered busy bits and sticky write-after-write error
//   REGFILE_BYPASS_EN     : when defined, same-cycle writes bypass into the read ports
module regfile_sb #(
   parameter int XLEN = 64,
   parameter int DEPTH = 32,
   parameter int NR = 2,
   parameter int NW = 1,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NR*AW-1:0]   rs_addr,
   output logic [NR*XLEN-1:0] rs_data,
   output logic [NR-1:0]      rs_busy,
   input  logic [NW-1:0]      wr_en,
   input  logic [NW*AW-1:0]   wr_addr,
   input  logic [NW*XLEN-1:0] wr_data,
   input  logic               alloc_en,
   input  logic [AW-1:0]      alloc_addr,
   output logic [DEPTH-1:0]   busy_vec,
   output logic               err_waw
);
   logic [XLEN-1:0]  mem [DEPTH];
   logic [DEPTH-1:0] busy, busy_n, hit;
   logic             err, waw_hit;
   always_comb begin
      hit = '0;
      for (int k = 0; k < NW; k++)
         if (wr_en[k]) hit[wr_addr[k*AW +: AW]] = 1'b1;
   end
   // allocation is applied after release so it wins on a same-cycle collision
   always_comb begin
      busy_n = busy & ~hit;
      if (alloc_en) busy_n[alloc_addr] = 1'b1;
      busy_n[0] = 1'b0;
   end
   assign waw_hit = alloc_en && alloc_addr != '0 && busy[alloc_addr] && !hit[alloc_addr];
   // later loop iterations overwrite earlier ones, so the highest-index port wins
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         busy <= '0;
         err <= 1'b0;
      end else begin
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && wr_addr[k*AW +: AW] != '0)
               mem[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
         busy <= busy_n;
         if (waw_hit) err <= 1'b1;
      end
   end
   assign busy_vec = busy;
   assign err_waw = err;
   for (genvar r = 0; r < NR; r++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rs_addr[r*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic            byp;
      logic [XLEN-1:0] bd;
      always_comb begin
         byp = 1'b0;
         bd = '0;
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && wr_addr[k*AW +: AW] == a) begin
               byp = 1'b1;
               bd = wr_data[k*XLEN +: XLEN];
            end
      end
      // a bypassed write releases the register unless it is re-allocated this cycle
      assign rs_data[r*XLEN +: XLEN] = a == '0 ? '0 : byp ? bd : mem[a];
      assign rs_busy[r] = a != '0 && (byp ? alloc_en && alloc_addr == a : busy[a]);
`else
      assign rs_data[r*XLEN +: XLEN] = a == '0 ? '0 : mem[a];
      assign rs_busy[r] = a != '0 && busy[a];
`endif
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (NR=2, NW=2)
module tb_regfile_sb;
   localparam int XLEN = 64, DEPTH = 32, NR = 2, NW = 2, AW = 5;
   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [NR*AW-1:0]   rs_addr = '0;
   logic [NR*XLEN-1:0] rs_data;
   logic [NR-1:0]      rs_busy;
   logic [NW-1:0]      wr_en = '0;
   logic [NW*AW-1:0]   wr_addr = '0;
   logic [NW*XLEN-1:0] wr_data = '0;
   logic               alloc_en = 1'b0;
   logic [AW-1:0]      alloc_addr = '0;
   logic [DEPTH-1:0]   busy_vec;
   logic               err_waw;
   int checks = 0, errors = 0;

   regfile_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (
      .clock(clock), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
      .alloc_addr(alloc_addr), .busy_vec(busy_vec), .err_waw(err_waw)
   );

   always #5 clock = ~clock;

   task step;
      @(posedge clock);
      #1;
   endtask

   task idle;
      wr_en = '0;
      alloc_en = 1'b0;
      reset = 1'b0;
   endtask

   task rd(input logic [AW-1:0] a);
      rs_addr = {a, a};
      #1;
   endtask

   task test_reset;
      reset = 1'b1;
      step;
      step;
      idle;
      for (int a = 0; a < DEPTH; a++) begin
         rd(a[AW-1:0]);
         checks++;
         if (rs_data !== '0 || rs_busy !== '0) begin
            errors++;
            $display("FAIL reset_read x%0d data=%h busy=%b expected data=0 busy=0", a, rs_data, rs_busy);
         end
      end
      checks++;
      if (busy_vec !== '0 || err_waw !== 1'b0) begin
         errors++;
         $display("FAIL reset_state busy_vec=%h err_waw=%b expected 0 0", busy_vec, err_waw);
      end
   endtask

   task test_write_priority;
      wr_en = 2'b11;
      wr_addr = {5'd5, 5'd5};
      wr_data = {64'h2222, 64'h1111};
      step;
      idle;
      rd(5'd5);
      checks++;
      if (rs_data !== {64'h2222, 64'h2222}) begin
         errors++;
         $display("FAIL write_priority x5 got=%h expected both ports 0x2222", rs_data);
      end
   endtask

   task test_zero;
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd0};
      wr_data = {64'h0, 64'hDEAD};
      alloc_en = 1'b1;
      alloc_addr = 5'd0;
      step;
      idle;
      rd(5'd0);
      checks++;
      if (rs_data !== '0 || rs_busy !== '0) begin
         errors++;
         $display("FAIL zero_read data=%h busy=%b expected 0 0", rs_data, rs_busy);
      end
      checks++;
      if (busy_vec !== '0 || err_waw !== 1'b0) begin
         errors++;
         $display("FAIL zero_state busy_vec=%h err_waw=%b expected 0 0", busy_vec, err_waw);
      end
   endtask

   task test_waw;
      alloc_en = 1'b1;
      alloc_addr = 5'd7;
      step;
      idle;
      rd(5'd7);
      checks++;
      if (rs_busy !== 2'b11 || busy_vec !== 32'h80 || err_waw !== 1'b0) begin
         errors++;
         $display("FAIL alloc_x7 rs_busy=%b busy_vec=%h err=%b expected 11 00000080 0", rs_busy, busy_vec, err_waw);
      end
      alloc_en = 1'b1;
      step;
      idle;
      checks++;
      if (err_waw !== 1'b1 || busy_vec !== 32'h80) begin
         errors++;
         $display("FAIL waw_set err=%b busy_vec=%h expected 1 00000080", err_waw, busy_vec);
      end
      step;
      checks++;
      if (err_waw !== 1'b1) begin
         errors++;
         $display("FAIL waw_sticky err=%b expected 1", err_waw);
      end
      reset = 1'b1;
      step;
      idle;
      rd(5'd7);
      checks++;
      if (err_waw !== 1'b0 || busy_vec !== '0 || rs_busy !== 2'b00) begin
         errors++;
         $display("FAIL waw_reset err=%b busy_vec=%h rs_busy=%b expected 0 0 00", err_waw, busy_vec, rs_busy);
      end
      rd(5'd5);
      checks++;
      if (rs_data !== '0) begin
         errors++;
         $display("FAIL reset_clears_mem x5 got=%h expected 0", rs_data);
      end
   endtask

   task test_alloc_write;
      alloc_en = 1'b1;
      alloc_addr = 5'd9;
      wr_en = 2'b10;
      wr_addr = {5'd9, 5'd0};
      wr_data = {64'hABCD, 64'h0};
      step;
      idle;
      rd(5'd9);
      checks++;
      if (busy_vec !== 32'h200 || rs_data !== {64'hABCD, 64'hABCD} || rs_busy !== 2'b11 || err_waw !== 1'b0) begin
         errors++;
         $display("FAIL alloc_write x9 busy_vec=%h data=%h rs_busy=%b err=%b expected 00000200 abcd 11 0", busy_vec, rs_data, rs_busy, err_waw);
      end
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd9};
      wr_data = {64'h0, 64'h1234};
      step;
      idle;
      rd(5'd9);
      checks++;
      if (busy_vec !== '0 || rs_data !== {64'h1234, 64'h1234} || rs_busy !== 2'b00) begin
         errors++;
         $display("FAIL writeback_x9 busy_vec=%h data=%h rs_busy=%b expected 0 1234 00", busy_vec, rs_data, rs_busy);
      end
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd12};
      wr_data = {64'h0, 64'h77};
      step;
      idle;
      rd(5'd12);
      checks++;
      if (busy_vec !== '0 || rs_data !== {64'h77, 64'h77} || err_waw !== 1'b0) begin
         errors++;
         $display("FAIL unsolicited_x12 busy_vec=%h data=%h err=%b expected 0 77 0", busy_vec, rs_data, err_waw);
      end
   endtask

   task test_bypass;
      logic [63:0] exp_now;
      logic        exp_busy_now;
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd3};
      wr_data = {64'h0, 64'h11};
      step;
      wr_data = {64'h0, 64'h42};
      rd(5'd3);
`ifdef REGFILE_BYPASS_EN
      exp_now = 64'h42;
`else
      exp_now = 64'h11;
`endif
      checks++;
      if (rs_data !== {exp_now, exp_now} || rs_busy !== 2'b00) begin
         errors++;
         $display("FAIL bypass_same_cycle data=%h busy=%b expected %h 00", rs_data, rs_busy, exp_now);
      end
      step;
      idle;
      checks++;
      if (rs_data !== {64'h42, 64'h42}) begin
         errors++;
         $display("FAIL bypass_next_cycle data=%h expected 42", rs_data);
      end
      wr_en = 2'b10;
      wr_addr = {5'd3, 5'd0};
      wr_data = {64'h99, 64'h0};
      alloc_en = 1'b1;
      alloc_addr = 5'd3;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_now = 64'h99;
      exp_busy_now = 1'b1;
`else
      exp_now = 64'h42;
      exp_busy_now = 1'b0;
`endif
      checks++;
      if (rs_data !== {exp_now, exp_now} || rs_busy !== {exp_busy_now, exp_busy_now}) begin
         errors++;
         $display("FAIL bypass_alloc data=%h busy=%b expected %h %b", rs_data, rs_busy, exp_now, exp_busy_now);
      end
      step;
      idle;
      checks++;
      if (rs_data !== {64'h99, 64'h99} || rs_busy !== 2'b11 || busy_vec !== 32'h8 || err_waw !== 1'b0) begin
         errors++;
         $display("FAIL bypass_alloc_next data=%h busy=%b busy_vec=%h err=%b expected 99 11 00000008 0", rs_data, rs_busy, busy_vec, err_waw);
      end
      rs_addr = {5'd3, 5'd0};
      #1;
      checks++;
      if (rs_data !== {64'h99, 64'h0} || rs_busy !== 2'b10) begin
         errors++;
         $display("FAIL mixed_ports data=%h busy=%b expected port1=99 port0=0 busy 10", rs_data, rs_busy);
      end
   endtask

   initial begin
      test_reset;
      test_write_priority;
      test_zero;
      test_waw;
      test_alloc_write;
      test_bypass;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
